// File: rtl/frog_move_input_if.sv
// Button-side and move-pulse signals of the frog input conditioner.
// master drives keys/enable/hit and observes the pulses; slave is the conditioner.
interface frog_move_input_if;
  logic KEY_L, KEY_R, KEY_U, KEY_D;
  logic enable, hit;
  logic L, R, U, D;

  modport master (output KEY_L, KEY_R, KEY_U, KEY_D, enable, hit,
                  input  L, R, U, D);
  modport slave  (input  KEY_L, KEY_R, KEY_U, KEY_D, enable, hit,
                  output L, R, U, D);
endinterface

// File: rtl/frog_move_input.sv
// Turns four raw buttons into synchronised, prioritised, auto-repeating
// single-cycle move pulses, gated by enable and locked out after a hit.
module frog_move_input #(
  parameter int HOLD_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  frog_move_input_if.slave bus
);
  localparam int MAXC = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;
  // Values double as bit positions in the key and pulse vectors.
  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_e;

  logic [3:0]    key_raw, s1_q, s2_q;
  logic [3:0]    pulse_q, pulse_d;
  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign key_raw = {bus.KEY_D, bus.KEY_U, bus.KEY_R, bus.KEY_L};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      state_q <= IDLE;
      dir_q   <= DIR_U;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_raw;
      s2_q    <= s1_q;
      pulse_q <= pulse_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    if (bus.hit) begin
      state_d = LOCK;
      cnt_d   = '0;
    end else if (state_q == LOCK) begin
      // Stay locked until every button is let go, so a held key cannot re-move the frog.
      if (s2_q == 4'b0000) state_d = IDLE;
    end else if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s2_q != 4'b0000) begin
            if      (s2_q[DIR_U]) dir_d = DIR_U;
            else if (s2_q[DIR_D]) dir_d = DIR_D;
            else if (s2_q[DIR_L]) dir_d = DIR_L;
            else                  dir_d = DIR_R;
            pulse_d[dir_d] = 1'b1;
            cnt_d          = '0;
            state_d        = HOLD;
          end
        end
        HOLD: begin
          if (!s2_q[dir_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            pulse_d[dir_q] = 1'b1;
            cnt_d          = '0;
            state_d        = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!s2_q[dir_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == REP_LAST) begin
            pulse_d[dir_q] = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.L = pulse_q[DIR_L];
  assign bus.R = pulse_q[DIR_R];
  assign bus.U = pulse_q[DIR_U];
  assign bus.D = pulse_q[DIR_D];
endmodule

// File: tb/tb_frog_move_input.sv
// Directed phases plus random traffic, checked cycle by cycle against a
// behavioural model based on time elapsed since the first pulse of a press.
module tb_frog_move_input;
  localparam int HD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frog_move_input_if ifc ();
  frog_move_input #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Driven stimulus (bit 0 L, 1 R, 2 U, 3 D).
  logic [3:0] k;
  logic       en, h;

  // Model: two-sample key delay, current direction (-1 none, -2 locked), elapsed cycles.
  logic [3:0] ms1, ms2, mexp;
  int         mdir, melapsed;
  int         tally [4];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {ifc.D, ifc.U, ifc.R, ifc.L};
  endfunction

  task automatic model_clear();
    ms1 = '0; ms2 = '0; mexp = '0; mdir = -1; melapsed = 0;
  endtask

  task automatic model_step();
    logic [3:0] s2;
    s2   = ms2;
    ms2  = ms1;
    ms1  = k;
    mexp = '0;
    if (h) mdir = -2;
    else if (mdir == -2) begin
      if (s2 == 4'b0000) mdir = -1;
    end else if (!en) mdir = -1;
    else if (mdir == -1) begin
      if (s2 != 4'b0000) begin
        mdir = s2[2] ? 2 : s2[3] ? 3 : s2[0] ? 0 : 1;
        mexp[mdir] = 1'b1;
        melapsed = 0;
      end
    end else if (!s2[mdir]) mdir = -1;
    else begin
      melapsed++;
      if (melapsed == HD || (melapsed > HD && (melapsed - HD) % RP == 0))
        mexp[mdir] = 1'b1;
    end
  endtask

  task automatic drive(input logic [3:0] kk, input logic e, input logic hh);
    k = kk; en = e; h = hh;
    ifc.KEY_L = kk[0]; ifc.KEY_R = kk[1]; ifc.KEY_U = kk[2]; ifc.KEY_D = kk[3];
    ifc.enable = e; ifc.hit = hh;
  endtask

  task automatic tick(input string tag);
    logic [3:0] o;
    @(posedge clk);
    if (reset) model_clear(); else model_step();
    #1;
    o = outs();
    check(tag, o, mexp);
    n_cmp++;
    assert ($onehot0(o)) else begin
      n_err++;
      $error("FAIL onehot_%s: got %b want at most one bit", tag, o);
    end
    for (int i = 0; i < 4; i++) if (o[i]) tally[i]++;
  endtask

  task automatic run(input int n, input logic [3:0] kk, input logic e, input logic hh, input string tag);
    drive(kk, e, hh);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic clr_tally();
    for (int i = 0; i < 4; i++) tally[i] = 0;
  endtask

  initial begin
    model_clear();
    clr_tally();
    reset = 1'b1;
    drive(4'b0000, 1'b1, 1'b0);
    #1;
    check("reset_state", outs(), 4'b0000);
    run(3, 4'b0000, 1'b1, 1'b0, "in_reset");
    reset = 1'b0;
    run(4, 4'b0000, 1'b1, 1'b0, "idle");

    // Single press: one U pulse, no repeat.
    clr_tally();
    run(5, 4'b0100, 1'b1, 1'b0, "single");
    run(15, 4'b0000, 1'b1, 1'b0, "single_rel");
    check_int("single_U_count", tally[2], 1);

    // Auto-repeat: 30 cycles of R gives T, T+8, T+12 ... T+28.
    clr_tally();
    run(30, 4'b0010, 1'b1, 1'b0, "repeat");
    run(6, 4'b0000, 1'b1, 1'b0, "repeat_rel");
    check_int("repeat_R_count", tally[1], 7);
    check_int("repeat_others", tally[0] + tally[2] + tally[3], 0);

    // Simultaneous L+D: D wins, then L after D is released.
    clr_tally();
    run(6, 4'b1001, 1'b1, 1'b0, "simul");
    run(8, 4'b0001, 1'b1, 1'b0, "simul_L");
    run(5, 4'b0000, 1'b1, 1'b0, "simul_rel");
    check_int("simul_D_count", tally[3], 1);
    check_int("simul_L_count", tally[0], 1);

    // Hit lockout while U is held.
    clr_tally();
    run(5, 4'b0100, 1'b1, 1'b0, "hit_pre");
    run(1, 4'b0100, 1'b1, 1'b1, "hit");
    run(12, 4'b0100, 1'b1, 1'b0, "hit_lock");
    run(4, 4'b0000, 1'b1, 1'b0, "hit_rel");
    run(5, 4'b0001, 1'b1, 1'b0, "hit_L");
    run(4, 4'b0000, 1'b1, 1'b0, "hit_end");
    check_int("hit_U_count", tally[2], 1);
    check_int("hit_L_count", tally[0], 1);

    // Enable gating, then repeat cadence restarting on enable.
    clr_tally();
    run(10, 4'b0010, 1'b0, 1'b0, "en_off");
    check_int("en_off_count", tally[1], 0);
    run(14, 4'b0010, 1'b1, 1'b0, "en_on");
    run(5, 4'b0000, 1'b1, 1'b0, "en_rel");
    check_int("en_on_R_count", tally[1], 3);

    // Asynchronous reset in the middle of REPEAT.
    run(20, 4'b0010, 1'b1, 1'b0, "ar_pre");
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("async_reset_out", outs(), 4'b0000);
    run(2, 4'b0010, 1'b1, 1'b0, "ar_hold");
    reset = 1'b0;
    clr_tally();
    run(12, 4'b0010, 1'b1, 1'b0, "ar_after");
    check_int("ar_R_count", tally[1], 2);
    run(4, 4'b0000, 1'b1, 1'b0, "ar_rel");

    // Random traffic.
    drive(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] nk;
      logic       ne;
      nk = k; ne = en;
      if ($urandom_range(5) == 0) nk = 4'($urandom);
      if ($urandom_range(29) == 0) ne = ~en;
      drive(nk, ne, ($urandom_range(39) == 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
